// File: rtl/ekf_fusion_seq_if.sv
// Frame-in / result-out bundle for the EKF track-to-track fusion stage.
// master: the side that supplies sensor frames and consumes results.
// slave:  the fusion stage itself.
interface ekf_fusion_seq_if #(
  parameter int NUM_SENS  = 2,
  parameter int STATE_DIM = 6,
  parameter int XW        = 16,
  parameter int PW        = 32
);
  logic                              in_valid;
  logic                              in_ready;
  logic [NUM_SENS-1:0]               sens_en;
  logic [NUM_SENS*STATE_DIM*XW-1:0]  x_in;
  logic [NUM_SENS*STATE_DIM*PW-1:0]  p_in;
  logic                              out_valid;
  logic                              out_ready;
  logic [STATE_DIM*XW-1:0]           x_f;
  logic [STATE_DIM*PW-1:0]           p_f;
  logic                              div0_err;
  logic                              busy;

  modport master (
    output in_valid, sens_en, x_in, p_in, out_ready,
    input  in_ready, out_valid, x_f, p_f, div0_err, busy
  );

  modport slave (
    input  in_valid, sens_en, x_in, p_in, out_ready,
    output in_ready, out_valid, x_f, p_f, div0_err, busy
  );
endinterface

// File: rtl/ekf_fusion_seq.sv
// Sequential inverse-variance fusion of NUM_SENS diagonal-covariance tracks.
// One element / one extra sensor per fold, sharing a single radix-2
// restoring divider between the state and covariance quotients.
//
//  state   | meaning
//  --------+---------------------------------------------------------------
//  IDLE    | waiting for a frame, in_ready high
//  LOAD    | seed accumulator with lowest enabled sensor (or K==0 defaults)
//  MUL     | form nx = p2*x1 + p1*x2, np = p1*p2, d = p1+p2; arm divider
//  DIV_X   | XW quotient bits of |nx|/d, sign restored on the last step
//  DIV_P   | PW quotient bits of np/d
//  STORE   | write xa[e], pa[e]; pick next sensor or next element
//  DONE    | first cycle publishes result, then out_valid held until taken
module ekf_fusion_seq #(
  parameter int NUM_SENS  = 2,
  parameter int STATE_DIM = 6,
  parameter int XW        = 16,
  parameter int PW        = 32
) (
  input  logic              clk,
  input  logic              rst,
  ekf_fusion_seq_if.slave   bus
);

  localparam int SW  = (NUM_SENS  > 1) ? $clog2(NUM_SENS)  : 1;
  localparam int EW  = (STATE_DIM > 1) ? $clog2(STATE_DIM) : 1;
  localparam int LW  = (XW > PW) ? XW : PW;
  localparam int CW  = $clog2(LW + 1);
  localparam int NXW = PW + XW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_MUL, S_DIV_X, S_DIV_P, S_STORE, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [NUM_SENS*STATE_DIM*XW-1:0] x_lat_q;
  logic [NUM_SENS*STATE_DIM*PW-1:0] p_lat_q;
  logic [NUM_SENS-1:0]              en_q;

  logic signed [XW-1:0] xa_q [STATE_DIM];
  logic        [PW-1:0] pa_q [STATE_DIM];

  logic [EW-1:0]        e_q;
  logic [SW-1:0]        s_q;
  logic [CW-1:0]        cnt_q;
  logic [PW:0]          rem_q;
  logic [LW-1:0]        lo_q;
  logic [LW-1:0]        q_q;
  logic [PW:0]          d_q;
  logic [2*PW-1:0]      np_q;
  logic                 neg_q;
  logic signed [XW-1:0] x1_q;
  logic [XW-1:0]        xq_q;
  logic                 err_q;
  logic                 div0_q;
  logic                 out_valid_q;
  logic [STATE_DIM*XW-1:0] x_f_q;
  logic [STATE_DIM*PW-1:0] p_f_q;

  logic in_ready_w;
  logic accept;

  // Lowest enabled sensor with index >= lo; MSB flags that one exists.
  function automatic logic [SW:0] find_en(input logic [NUM_SENS-1:0] m, input int lo);
    logic [SW:0] r;
    r = '0;
    for (int i = NUM_SENS - 1; i >= 0; i--) begin
      if (m[i] && (i >= lo)) r = {1'b1, SW'(i)};
    end
    return r;
  endfunction

  logic [SW:0] first_w, second_w, next_w;

  // Sensor walk: seed sensor, first folding sensor, and the one after s_q.
  always_comb begin
    first_w  = find_en(en_q, 0);
    second_w = find_en(en_q, int'(first_w[SW-1:0]) + 1);
    next_w   = find_en(en_q, int'(s_q) + 1);
  end

  assign in_ready_w = (state_q == S_IDLE) && !rst;
  assign accept     = bus.in_valid && in_ready_w;

  logic signed [XW-1:0]  x1, x2;
  logic        [PW-1:0]  p1, p2;
  logic signed [NXW-1:0] p1s, p2s, x1s, x2s, nx;
  logic        [NXW-1:0] absnx;
  logic        [2*PW-1:0] np;
  logic        [PW:0]    d;

  // Fold operands and the MUL-stage products/sum.
  always_comb begin
    x1    = xa_q[e_q];
    p1    = pa_q[e_q];
    x2    = x_lat_q[(int'(s_q) * STATE_DIM + int'(e_q)) * XW +: XW];
    p2    = p_lat_q[(int'(s_q) * STATE_DIM + int'(e_q)) * PW +: PW];
    p1s   = {{(XW+1){1'b0}}, p1};
    p2s   = {{(XW+1){1'b0}}, p2};
    x1s   = {{(PW+1){x1[XW-1]}}, x1};
    x2s   = {{(PW+1){x2[XW-1]}}, x2};
    nx    = p2s * x1s + p1s * x2s;
    absnx = nx[NXW-1] ? -nx : nx;
    np    = {{PW{1'b0}}, p1} * {{PW{1'b0}}, p2};
    d     = {1'b0, p1} + {1'b0, p2};
  end

  logic [PW+1:0] trial, diff;
  logic          ge;
  logic [PW:0]   rem_n;
  logic [LW-1:0] lo_n, q_n;

  // One restoring-divide step: shift in next dividend bit, subtract if it fits.
  always_comb begin
    trial = {rem_q, lo_q[LW-1]};
    diff  = trial - {1'b0, d_q};
    ge    = (trial >= {1'b0, d_q});
    rem_n = ge ? diff[PW:0] : trial[PW:0];
    lo_n  = {lo_q[LW-2:0], 1'b0};
    q_n   = {q_q[LW-2:0], ge};
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_LOAD;
      S_LOAD:  state_d = second_w[SW] ? S_MUL : S_DONE;
      S_MUL:   state_d = S_DIV_X;
      S_DIV_X: if (cnt_q == '0) state_d = S_DIV_P;
      S_DIV_P: if (cnt_q == '0) state_d = S_STORE;
      S_STORE: begin
        if (next_w[SW])                          state_d = S_MUL;
        else if (int'(e_q) == STATE_DIM - 1)     state_d = S_DONE;
        else                                     state_d = S_MUL;
      end
      S_DONE:  if (out_valid_q && bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: input latch, accumulator, shared divider and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_lat_q     <= '0;
      p_lat_q     <= '0;
      en_q        <= '0;
      for (int e = 0; e < STATE_DIM; e++) begin
        xa_q[e] <= '0;
        pa_q[e] <= '0;
      end
      e_q         <= '0;
      s_q         <= '0;
      cnt_q       <= '0;
      rem_q       <= '0;
      lo_q        <= '0;
      q_q         <= '0;
      d_q         <= '0;
      np_q        <= '0;
      neg_q       <= 1'b0;
      x1_q        <= '0;
      xq_q        <= '0;
      err_q       <= 1'b0;
      div0_q      <= 1'b0;
      out_valid_q <= 1'b0;
      x_f_q       <= '0;
      p_f_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            x_lat_q <= bus.x_in;
            p_lat_q <= bus.p_in;
            en_q    <= bus.sens_en;
            err_q   <= 1'b0;
            div0_q  <= 1'b0;
          end
        end
        S_LOAD: begin
          for (int e = 0; e < STATE_DIM; e++) begin
            if (first_w[SW]) begin
              xa_q[e] <= x_lat_q[(int'(first_w[SW-1:0]) * STATE_DIM + e) * XW +: XW];
              pa_q[e] <= p_lat_q[(int'(first_w[SW-1:0]) * STATE_DIM + e) * PW +: PW];
            end else begin
              xa_q[e] <= '0;
              pa_q[e] <= '1;
            end
          end
          if (!first_w[SW]) err_q <= 1'b1;
          e_q <= '0;
          s_q <= second_w[SW-1:0];
        end
        S_MUL: begin
          // |nx| < d * 2^XW, so its upper bits already form a remainder below d.
          rem_q <= absnx[NXW-1:XW];
          lo_q  <= LW'(absnx[XW-1:0]) << (LW - XW);
          q_q   <= '0;
          neg_q <= nx[NXW-1];
          np_q  <= np;
          d_q   <= d;
          x1_q  <= x1;
          cnt_q <= CW'(XW - 1);
        end
        S_DIV_X: begin
          if (cnt_q == '0) begin
            xq_q  <= neg_q ? -q_n[XW-1:0] : q_n[XW-1:0];
            rem_q <= {1'b0, np_q[2*PW-1:PW]};
            lo_q  <= LW'(np_q[PW-1:0]) << (LW - PW);
            q_q   <= '0;
            cnt_q <= CW'(PW - 1);
          end else begin
            rem_q <= rem_n;
            lo_q  <= lo_n;
            q_q   <= q_n;
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_DIV_P: begin
          rem_q <= rem_n;
          lo_q  <= lo_n;
          q_q   <= q_n;
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        end
        S_STORE: begin
          // Zero combined variance: keep the accumulator's state, flag it.
          if (d_q == '0) begin
            xa_q[e_q] <= x1_q;
            pa_q[e_q] <= '0;
            err_q     <= 1'b1;
          end else begin
            xa_q[e_q] <= xq_q;
            pa_q[e_q] <= q_q[PW-1:0];
          end
          if (next_w[SW]) begin
            s_q <= next_w[SW-1:0];
          end else begin
            e_q <= e_q + 1'b1;
            s_q <= second_w[SW-1:0];
          end
        end
        S_DONE: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            div0_q      <= err_q;
            for (int e = 0; e < STATE_DIM; e++) begin
              x_f_q[e*XW +: XW] <= xa_q[e];
              p_f_q[e*PW +: PW] <= pa_q[e];
            end
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_q;
  assign bus.x_f       = x_f_q;
  assign bus.p_f       = p_f_q;
  assign bus.div0_err  = div0_q;
  assign bus.busy      = (state_q != S_IDLE) && !out_valid_q;

endmodule

// File: tb/tb_ekf_fusion_seq.sv
// Directed bench for ekf_fusion_seq with NUM_SENS=2, STATE_DIM=6, XW=16, PW=32.
module tb_ekf_fusion_seq;
  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ekf_fusion_seq_if #(.NUM_SENS(2), .STATE_DIM(6), .XW(16), .PW(32)) bus ();

  ekf_fusion_seq #(.NUM_SENS(2), .STATE_DIM(6), .XW(16), .PW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Same (x,p) on every element for sensor 0 (xa,pa) and sensor 1 (xb,pb).
  task automatic fill(input logic [1:0] m, input logic signed [15:0] xa, input logic signed [15:0] xb,
                      input logic [31:0] pa, input logic [31:0] pb);
    bus.sens_en = m;
    for (int e = 0; e < 6; e++) begin
      bus.x_in[(0*6+e)*16 +: 16] = xa;
      bus.x_in[(1*6+e)*16 +: 16] = xb;
      bus.p_in[(0*6+e)*32 +: 32] = pa;
      bus.p_in[(1*6+e)*32 +: 32] = pb;
    end
  endtask

  // Offer the frame, scramble inputs right after accept, count edges to out_valid.
  task automatic run_frame(output int lat, output logic busy_seen);
    int w;
    w = 0;
    while (bus.in_ready !== 1'b1 && w < 100) begin
      @(posedge clk); #1; w++;
    end
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.x_in     = ~bus.x_in;
    bus.p_in     = ~bus.p_in;
    bus.sens_en  = ~bus.sens_en;
    busy_seen    = bus.busy;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 2000) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic pop();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.div0_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b div0=%b, want all 0",
               bus.in_ready, bus.out_valid, bus.busy, bus.div0_err);
    end
    n_vec++;
    if (bus.x_f !== '0 || bus.p_f !== '0) begin
      n_err++;
      $display("FAIL reset_data: x_f=%h p_f=%h, want 0", bus.x_f, bus.p_f);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release_ready: in_ready=%b want 1", bus.in_ready);
    end
  endtask

  task automatic test_equal_weights();
    int lat; logic b;
    fill(2'b11, 16'sd100, 16'sd200, 32'h0001_0000, 32'h0001_0000);
    run_frame(lat, b);
    n_vec++;
    if (lat !== 302) begin
      n_err++; $display("FAIL t1_latency: got %0d want 302", lat);
    end
    n_vec++;
    if (b !== 1'b1 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL t1_busy: after accept %b (want 1), at out_valid %b (want 0)", b, bus.busy);
    end
    n_vec++;
    if (bus.div0_err !== 1'b0) begin
      n_err++; $display("FAIL t1_div0: got %b want 0", bus.div0_err);
    end
    for (int e = 0; e < 6; e++) begin
      n_vec++;
      if ($signed(bus.x_f[e*16 +: 16]) !== 16'sd150 || bus.p_f[e*32 +: 32] !== 32'h0000_8000) begin
        n_err++;
        $display("FAIL t1_elem%0d: x=%0d p=%h want x=150 p=00008000", e,
                 $signed(bus.x_f[e*16 +: 16]), bus.p_f[e*32 +: 32]);
      end
    end
    pop();
  endtask

  task automatic test_unequal_weights();
    int lat; logic b;
    fill(2'b11, 16'sd0, 16'sd400, 32'h0001_0000, 32'h0003_0000);
    run_frame(lat, b);
    for (int e = 0; e < 6; e++) begin
      n_vec++;
      if (bus.out_valid !== 1'b1 || $signed(bus.x_f[e*16 +: 16]) !== 16'sd100 ||
          bus.p_f[e*32 +: 32] !== 32'h0000_C000) begin
        n_err++;
        $display("FAIL t2_elem%0d: ov=%b x=%0d p=%h want ov=1 x=100 p=0000c000", e, bus.out_valid,
                 $signed(bus.x_f[e*16 +: 16]), bus.p_f[e*32 +: 32]);
      end
    end
    pop();
  endtask

  task automatic test_truncation();
    int lat; logic b;
    fill(2'b11, -16'sd7, 16'sd0, 32'h0001_0000, 32'h0001_0000);
    run_frame(lat, b);
    for (int e = 0; e < 6; e++) begin
      n_vec++;
      if (bus.out_valid !== 1'b1 || $signed(bus.x_f[e*16 +: 16]) !== -16'sd3 ||
          bus.p_f[e*32 +: 32] !== 32'h0000_8000) begin
        n_err++;
        $display("FAIL t3_elem%0d: ov=%b x=%0d p=%h want ov=1 x=-3 p=00008000", e, bus.out_valid,
                 $signed(bus.x_f[e*16 +: 16]), bus.p_f[e*32 +: 32]);
      end
    end
    pop();
  endtask

  task automatic test_mask();
    int lat; logic b;
    fill(2'b10, 16'sd7777, 16'sd0, 32'd5, 32'd0);
    for (int e = 0; e < 6; e++) begin
      bus.x_in[(6+e)*16 +: 16] = 16'(e*1000 - 2500);
      bus.p_in[(6+e)*32 +: 32] = 32'h0002_0000 + 32'(e);
    end
    run_frame(lat, b);
    n_vec++;
    if (lat !== 2 || bus.div0_err !== 1'b0) begin
      n_err++; $display("FAIL t4_single_lat: lat=%0d div0=%b want 2/0", lat, bus.div0_err);
    end
    for (int e = 0; e < 6; e++) begin
      n_vec++;
      if ($signed(bus.x_f[e*16 +: 16]) !== 16'(e*1000 - 2500) ||
          bus.p_f[e*32 +: 32] !== 32'h0002_0000 + 32'(e)) begin
        n_err++;
        $display("FAIL t4_single_elem%0d: x=%0d p=%h want x=%0d p=%h", e, $signed(bus.x_f[e*16 +: 16]),
                 bus.p_f[e*32 +: 32], e*1000 - 2500, 32'h0002_0000 + 32'(e));
      end
    end
    pop();
    fill(2'b00, 16'sd11, 16'sd22, 32'd3, 32'd4);
    run_frame(lat, b);
    n_vec++;
    if (lat !== 2 || bus.div0_err !== 1'b1 || bus.x_f !== '0 || bus.p_f !== {6{32'hFFFF_FFFF}}) begin
      n_err++;
      $display("FAIL t4_none: lat=%0d div0=%b x_f=%h p_f=%h want 2/1/0/all-ones", lat, bus.div0_err,
               bus.x_f, bus.p_f);
    end
    pop();
  endtask

  task automatic test_div0();
    int lat; logic b;
    fill(2'b11, 16'sd100, 16'sd200, 32'h0001_0000, 32'h0001_0000);
    bus.x_in[(0*6+3)*16 +: 16] = 16'sd55;
    bus.x_in[(1*6+3)*16 +: 16] = 16'sd9;
    bus.p_in[(0*6+3)*32 +: 32] = 32'd0;
    bus.p_in[(1*6+3)*32 +: 32] = 32'd0;
    run_frame(lat, b);
    n_vec++;
    if (lat !== 302 || bus.div0_err !== 1'b1) begin
      n_err++; $display("FAIL t5_div0: lat=%0d div0=%b want 302/1", lat, bus.div0_err);
    end
    for (int e = 0; e < 6; e++) begin
      n_vec++;
      if ((e == 3 && ($signed(bus.x_f[e*16 +: 16]) !== 16'sd55 || bus.p_f[e*32 +: 32] !== 32'd0)) ||
          (e != 3 && ($signed(bus.x_f[e*16 +: 16]) !== 16'sd150 || bus.p_f[e*32 +: 32] !== 32'h0000_8000))) begin
        n_err++;
        $display("FAIL t5_elem%0d: x=%0d p=%h want %s", e, $signed(bus.x_f[e*16 +: 16]),
                 bus.p_f[e*32 +: 32], (e == 3) ? "x=55 p=0" : "x=150 p=00008000");
      end
    end
    pop();
  endtask

  task automatic test_hold_and_reset();
    int lat; logic b; logic stable;
    logic [6*16-1:0] xs; logic [6*32-1:0] ps;
    fill(2'b11, 16'sd0, 16'sd400, 32'h0001_0000, 32'h0003_0000);
    run_frame(lat, b);
    xs = bus.x_f; ps = bus.p_f;
    stable = bus.out_valid;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.x_f !== xs || bus.p_f !== ps) stable = 1'b0;
    end
    n_vec++;
    if (stable !== 1'b1) begin
      n_err++; $display("FAIL t6_hold: result not held (ov=%b in_ready=%b) want stable", bus.out_valid, bus.in_ready);
    end
    pop();
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.x_f !== xs) begin
      n_err++;
      $display("FAIL t6_release: ov=%b in_ready=%b x_f_kept=%b want 0/1/1", bus.out_valid, bus.in_ready, bus.x_f === xs);
    end
    fill(2'b11, 16'sd1, 16'sd2, 32'h0001_0000, 32'h0001_0000);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.x_f !== '0 || bus.p_f !== '0) begin
      n_err++;
      $display("FAIL t6_midreset: ov=%b busy=%b in_ready=%b x_f=%h want 0/0/0/0", bus.out_valid, bus.busy,
               bus.in_ready, bus.x_f);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_vec++;
    if (bus.in_ready !== 1'b1) begin
      n_err++; $display("FAIL t6_ready_after_reset: in_ready=%b want 1", bus.in_ready);
    end
    fill(2'b11, 16'sd100, 16'sd200, 32'h0001_0000, 32'h0001_0000);
    run_frame(lat, b);
    n_vec++;
    if (lat !== 302 || bus.div0_err !== 1'b0) begin
      n_err++; $display("FAIL t6_refuse: lat=%0d div0=%b want 302/0", lat, bus.div0_err);
    end
    for (int e = 0; e < 6; e++) begin
      n_vec++;
      if ($signed(bus.x_f[e*16 +: 16]) !== 16'sd150 || bus.p_f[e*32 +: 32] !== 32'h0000_8000) begin
        n_err++;
        $display("FAIL t6_elem%0d: x=%0d p=%h want x=150 p=00008000", e,
                 $signed(bus.x_f[e*16 +: 16]), bus.p_f[e*32 +: 32]);
      end
    end
    pop();
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.sens_en   = '0;
    bus.x_in      = '0;
    bus.p_in      = '0;
    test_reset();
    test_equal_weights();
    test_unequal_weights();
    test_truncation();
    test_mask();
    test_div0();
    test_hold_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
